// File: rtl/data_memory_preload.sv
// Parametrised data memory with combinational read, synchronous write and an init FSM
// that preloads a fixed table window and zeroes the rest. DMEM_REGISTERED_READ_EN registers out.
module data_memory_preload #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int INIT_BASE = 100,
    parameter int INIT_LEN  = 22
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              reinit,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              ready,
    output logic              wr_drop
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {INIT, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    function automatic logic [DATA_W-1:0] tbl(input int i);
        logic [7:0] v;
        case (i)
            0: v = 8'd10;   1: v = 8'd7;    2: v = 8'd75;   3: v = 8'd9;
            4: v = 8'd3;    5: v = 8'd4;    6: v = 8'd5;    7: v = 8'd6;
            8: v = 8'd7;    9: v = 8'd8;   10: v = 8'd9;   11: v = 8'd90;
           12: v = 8'd10;  13: v = 8'd12;  14: v = 8'd13;  15: v = 8'd14;
           16: v = 8'd15;  17: v = 8'd120; 18: v = 8'd1;   19: v = 8'd1;
           20: v = 8'd1;   21: v = 8'd1;
            default: v = 8'd0;
        endcase
        return DATA_W'(v);
    endfunction

    // Entries past DEPTH are never reached by ptr, so they drop out naturally.
    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] p);
        int pi;
        pi = int'(p);
        if (pi >= INIT_BASE && pi < INIT_BASE + INIT_LEN)
            return tbl(pi - INIT_BASE);
        return '0;
    endfunction

    always_comb begin
        we = 1'b0;
        wa = address;
        wd = data;
        if (state == INIT && !reinit) begin
            we = 1'b1;
            wa = ptr;
            wd = preload(ptr);
        end else if (state == READY && mem_write && !reinit) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (we)
            mem[wa] <= wd;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            ptr     <= '0;
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            // A write is lost whenever the array is busy or a reinit takes the cycle.
            wr_drop <= mem_write && (!ready || reinit);
            if (reinit) begin
                state <= INIT;
                ptr   <= '0;
                ready <= 1'b0;
            end else if (state == INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == '1) begin
                    state <= READY;
                    ready <= 1'b1;
                end
            end
        end
    end

`ifdef DMEM_REGISTERED_READ_EN
    // Write-first: a same-cycle write to the read address forwards the new data.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else if (!ready)
            out <= '0;
        else if (we && wa == address)
            out <= wd;
        else
            out <= mem[address];
    end
`else
    assign out = ready ? mem[address] : '0;
`endif

endmodule

// File: tb/tb_data_memory_preload.sv
// Directed bench for data_memory_preload: default 256x8 instance plus a 64x4 instance.
module tb_data_memory_preload;
    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       reinit = 1'b0;
    logic       mem_write = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] data = '0;
    logic [7:0] out;
    logic       ready, wr_drop;

    logic       s_reinit = 1'b0;
    logic       s_mem_write = 1'b0;
    logic [5:0] s_address = '0;
    logic [3:0] s_data = '0;
    logic [3:0] s_out;
    logic       s_ready, s_wr_drop;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];
    string tag_q[$];
    int TBL[22] = '{10,7,75,9,3,4,5,6,7,8,9,90,10,12,13,14,15,120,1,1,1,1};

    data_memory_preload dut (
        .clock(clock), .rst_n(rst_n), .reinit(reinit), .mem_write(mem_write),
        .address(address), .data(data), .out(out), .ready(ready), .wr_drop(wr_drop)
    );

    data_memory_preload #(.DATA_W(4), .ADDR_W(6), .INIT_BASE(60), .INIT_LEN(22)) dut_s (
        .clock(clock), .rst_n(rst_n), .reinit(s_reinit), .mem_write(s_mem_write),
        .address(s_address), .data(s_data), .out(s_out), .ready(s_ready), .wr_drop(s_wr_drop)
    );

    always #5 clock = ~clock;

    function automatic int exp_word(input int a, input int base, input int dw);
        if (a >= base && a < base + 22)
            return TBL[a - base] & ((1 << dw) - 1);
        return 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected value queued at drive time, popped when out is sampled on the falling edge.
    task automatic sb_read(input bit sm, input string tag, input int a, input int e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (sm) s_address = 6'(a);
        else    address = 8'(a);
        @(negedge clock);
        chk(tag_q.pop_front(), sm ? int'(s_out) : int'(out), exp_q.pop_front());
        tick();
    endtask

    initial begin
        repeat (2) tick();
        address = 8'd100;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_out", out, 0);

        // first sweep: ready after exactly DEPTH edges, drop during INIT
        rst_n = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i == 10) begin mem_write = 1'b1; address = 8'd5; data = 8'h77; end
            if (i == 11) begin chk("init_drop", wr_drop, 1); mem_write = 1'b0; end
            if (i == 12) chk("init_drop_clr", wr_drop, 0);
            if (i == 63) chk("s_ready_63", s_ready, 0);
            if (i == 64) chk("s_ready_64", s_ready, 1);
            if (i == 200) begin address = 8'd100; #1; chk("init_out0", out, 0); end
        end
        chk("ready_255", ready, 0);
        tick();
        chk("ready_256", ready, 1);

        sb_read(0, "w100", 100, 10);
        sb_read(0, "w102", 102, 75);
        sb_read(0, "w111", 111, 90);
        sb_read(0, "w117", 117, 120);
        sb_read(0, "w121", 121, 1);
        sb_read(0, "w99", 99, 0);
        sb_read(0, "w122", 122, 0);
        sb_read(0, "w5_dropped", 5, 0);
        sb_read(1, "s60", 60, 10);
        sb_read(1, "s61", 61, 7);
        sb_read(1, "s62", 62, 11);
        sb_read(1, "s63", 63, 9);
        sb_read(1, "s59", 59, 0);

        // READY write; read-during-write shows old data until the edge
        data = 8'hA5;
        mem_write = 1'b1;
        sb_read(0, "rdw_old", 7, 0);
        mem_write = 1'b0;
        sb_read(0, "w7_new", 7, 8'hA5);
        sb_read(0, "w8", 8, 0);
        chk("ready_no_drop", wr_drop, 0);

        // reinit together with a write: write lost, full resweep
        data = 8'h33;
        address = 8'd100;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        sb_read(0, "w100_33", 100, 8'h33);
        reinit = 1'b1; mem_write = 1'b1; address = 8'd3; data = 8'h55;
        tick();
        reinit = 1'b0; mem_write = 1'b0;
        chk("reinit_drop", wr_drop, 1);
        chk("reinit_ready", ready, 0);
        repeat (255) tick();
        chk("reinit_ready_255", ready, 0);
        tick();
        chk("reinit_ready_256", ready, 1);
        chk("reinit_drop_clr", wr_drop, 0);
        sb_read(0, "re_w100", 100, 10);
        sb_read(0, "re_w3", 3, 0);
        sb_read(0, "re_w7", 7, 0);

        // async reset while READY hides the array at once
        address = 8'd100;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ready, 0);
        chk("arst_out", out, 0);
        tick();
        rst_n = 1'b1;
        repeat (50) tick();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        repeat (129) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_ready", ready, 0);
        tick();
        rst_n = 1'b1;
        repeat (255) tick();
        chk("mid_ready_255", ready, 0);
        tick();
        chk("mid_ready_256", ready, 1);
        for (int a = 0; a < 256; a++)
            sb_read(0, $sformatf("full_%0d", a), a, exp_word(a, 100, 8));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_preload.md
Name: data_memory_preload

Overview:
- Parametrised successor to the 8-bit/256-word data memory used by the datapath load/store stage.
- Width and depth are generic. Reads are combinational, writes are synchronous.
- After reset, and on request, an FSM sweeps the whole array: it writes a fixed preload table into a configurable window and zeroes every other word.
- A ready flag gates all accesses. Writes issued while the memory is busy are dropped and flagged.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- INIT_BASE, 100, address of preload table entry 0.
- INIT_LEN, 22, number of preload entries used (1..22).

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- reinit  in  1  single-cycle pulse; restarts the init sweep.
- mem_write  in  1  write enable, sampled on rising edge.
- address  in  ADDR_W  read/write address.
- data  in  DATA_W  write data.
- out  out  DATA_W  read data.
- ready  out  1  array initialised; accesses valid.
- wr_drop  out  1  one-cycle pulse: a write was discarded.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: ready=0, wr_drop=0, init pointer=0, FSM state=INIT. Array contents are not reset.
- Preload table, entries 0..21: 10,7,75,9,3,4,5,6,7,8,9,90,10,12,13,14,15,120,1,1,1,1. Values are truncated to DATA_W LSBs.
- FSM states: INIT and READY.
- INIT state:
  - Each rising edge writes word[ptr], then ptr increments.
  - If INIT_BASE <= ptr < INIT_BASE+INIT_LEN, the value written is table[ptr-INIT_BASE]; otherwise it is 0.
  - Table entries falling at or beyond DEPTH are discarded; no wrap.
- INIT -> READY: at the edge that writes ptr=DEPTH-1, ready goes to 1 on that same edge. The sweep therefore takes exactly DEPTH cycles after rst_n deasserts.
- READY state:
  - mem_write=1 at a rising edge: word[address] <= data.
  - reinit=1: go to INIT with ptr=0, and ready=0 from the next cycle.
- Read path:
  - out = ready ? word[address] : 0, combinational.
  - Read-during-write returns the old word until the edge, then the new word.
- Write drops:
  - mem_write=1 while ready=0 is ignored; wr_drop=1 for the next cycle.
  - mem_write and reinit in the same READY cycle: reinit wins, the write is dropped, wr_drop pulses.
- Boundary cases:
  - reinit during INIT restarts ptr at 0; the sweep length is again DEPTH cycles.
  - rst_n asserted mid-sweep: ready drops immediately and the sweep restarts from 0 after deassert. The partially swept array must not be readable; out=0.
  - Address wraps naturally at 2**ADDR_W; there is no out-of-range access.
  - wr_drop is registered and deasserts after one cycle unless drops repeat.

Optional Feature:
- Macro: DMEM_REGISTERED_READ_EN.
- Defined:
  - out is registered: out <= ready ? word[address] : 0 on each rising edge, giving 1-cycle read latency.
  - A write and a read to the same address in one cycle return the new data (write-first).
  - out resets to 0.
- Undefined: combinational read as described in Behaviour.

Test Plan:
- Release rst_n with DEPTH=256 -> ready rises exactly 256 cycles later; word[100]=10, word[102]=75, word[111]=90, word[117]=120, word[121]=1, word[99]=0, word[122]=0.
- In READY, write 0xA5 to address 7, then read address 7 -> out=0xA5 on the following cycle; address 8 still reads 0.
- mem_write=1 with address 5 during INIT -> wr_drop high for one cycle; word[5]=0 after ready.
- Write 0x33 to address 100, then pulse reinit together with mem_write to address 3 -> wr_drop=1, ready=0 for 256 cycles; afterwards word[100]=10 and word[3]=0.
- Assert rst_n low at sweep cycle 130, release -> out=0 immediately; ready rises 256 cycles after release; table contents intact.
- DATA_W=4, ADDR_W=6, INIT_BASE=60 -> ready after 64 cycles; word[60..63] = 10,7,11,9 (75 truncated to 4 bits), and the remaining entries are discarded. Rerun with DMEM_REGISTERED_READ_EN defined to confirm 1-cycle read latency and write-first behaviour.
